mem_responder: RTL and testbench

Memory-side responder for the microprogrammed controller's bus. It accepts read/write strobes decoded from the controller's control word and serves them from an internal 16-bit word memory with a fixed, parameterised access latency. It drives the `wait_` status the controller's microsequencer branches on. It sits between the controller/MAR/MBR datapath and main memory, and owns all memory timing.

---
 rtl/sam_pkg.sv | 14 +
 rtl/mem_resp_ram.sv | 21 ++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// Shared types and constants for the memory responder and its RAM.
package sam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_W      = 16;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word array: synchronous write, asynchronous read of the addressed word.
module mem_resp_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder driving the controller's wait_ status.
// Define MEM_RESP_PARITY_EN to store an even-parity bit per word and flag read mismatches.
module mem_responder
  import sam_pkg::*;
#(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              wait_,
  output logic              parity_err
);

`ifdef MEM_RESP_PARITY_EN
  localparam int RAM_W = WORD_W + 1;
`else
  localparam int RAM_W = WORD_W;
`endif

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [AW-1:0]     r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_isWrite;
  logic [WORD_W-1:0] r_rdata;
  logic              r_rdataValid;
  logic              r_wait;
  logic              w_accept;
  logic              w_finish;
  logic              w_ramWe;
  logic [RAM_W-1:0]  w_ramWdata;
  logic [RAM_W-1:0]  w_ramRdata;

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (mem_rd || mem_wr) begin
          w_nextState = BUSY;
          w_accept    = 1'b1;
        end else begin
          w_nextState = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_nextState = DONE;
          w_finish    = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A reset on the committing edge must leave the old word intact.
  assign w_ramWe = w_finish && r_isWrite && !reset;

`ifdef MEM_RESP_PARITY_EN
  assign w_ramWdata = {^r_wdata, r_wdata};
`else
  assign w_ramWdata = r_wdata;
`endif

  mem_resp_ram #(
    .AW (AW),
    .DW (RAM_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_addr  (r_addr),
    .i_wdata (w_ramWdata),
    .o_rdata (w_ramRdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wait       <= 1'b0;
      r_rdata      <= '0;
      r_rdataValid <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_wait       <= (w_nextState == BUSY);
      r_rdataValid <= w_finish && !r_isWrite;
      if (w_accept) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish && !r_isWrite) r_rdata <= w_ramRdata[WORD_W-1:0];
    end
  end

  // Request fields are only consumed while BUSY, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr    <= addr;
      r_wdata   <= wdata;
      r_isWrite <= mem_wr;
    end
  end

`ifdef MEM_RESP_PARITY_EN
  logic r_parityErr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_parityErr <= 1'b0;
    end else begin
      r_parityErr <= w_finish && !r_isWrite && (^w_ramRdata);
    end
  end

  assign parity_err = r_parityErr;
`else
  assign parity_err = 1'b0;
`endif

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdataValid;
  assign wait_       = r_wait;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2, AW=8).
// Define MEM_RESP_PARITY_EN to include the parity corruption case.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        wait_;
  logic        parity_err;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .AW      (8),
    .LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .wait_       (wait_),
    .parity_err  (parity_err)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [15:0] expData);
    checkOutput({tag, "_wait"},  16'(wait_), 16'h0);
    checkOutput({tag, "_valid"}, 16'(rdata_valid), 16'h0);
    checkOutput({tag, "_perr"},  16'(parity_err), 16'h0);
    checkOutput({tag, "_rdata"}, rdata, expData);
  endtask

  // One strobe cycle, then LAT busy cycles, the DONE cycle and one idle cycle.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [7:0] a, input logic [15:0] d,
                               input logic expValid, input logic [15:0] expData,
                               input logic expPerr);
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      checkOutput({tag, "_busyWait"},  16'(wait_), 16'h1);
      checkOutput({tag, "_busyValid"}, 16'(rdata_valid), 16'h0);
      @(negedge clk);
    end
    checkOutput({tag, "_doneWait"},  16'(wait_), 16'h0);
    checkOutput({tag, "_doneValid"}, 16'(rdata_valid), 16'(expValid));
    checkOutput({tag, "_donePerr"},  16'(parity_err), 16'(expPerr));
    checkOutput({tag, "_doneRdata"}, rdata, expData);
    @(negedge clk);
    checkIdle({tag, "_after"}, expData);
  endtask

  initial begin
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkIdle("reset", 16'h0000);
    reset = 1'b0;

    applyStimulus("wrBeef", 1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    applyStimulus("rdBeef", 1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
    applyStimulus("bothHi", 1'b1, 1'b1, 8'h05, 16'h0001, 1'b0, 16'hBEEF, 1'b0);
    applyStimulus("rd05",   1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 16'h0001, 1'b0);
    applyStimulus("wr5555", 1'b0, 1'b1, 8'h20, 16'h5555, 1'b0, 16'h0001, 1'b0);

    // Back-to-back: second read strobed during the DONE cycle of the first.
    @(negedge clk);
    mem_rd = 1'b1; addr = 8'h12;
    @(negedge clk);
    mem_rd = 1'b0;
    checkOutput("b2bFirstWait", 16'(wait_), 16'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2bFirstDoneWait",  16'(wait_), 16'h0);
    checkOutput("b2bFirstDoneValid", 16'(rdata_valid), 16'h1);
    checkOutput("b2bFirstDoneRdata", rdata, 16'hBEEF);
    mem_rd = 1'b1; addr = 8'h05;
    @(negedge clk);
    mem_rd = 1'b0;
    checkOutput("b2bSecondWait",  16'(wait_), 16'h1);
    checkOutput("b2bSecondValid", 16'(rdata_valid), 16'h0);
    @(negedge clk);
    checkOutput("b2bSecondWait2", 16'(wait_), 16'h1);
    @(negedge clk);
    checkOutput("b2bSecondDoneValid", 16'(rdata_valid), 16'h1);
    checkOutput("b2bSecondDoneRdata", rdata, 16'h0001);
    @(negedge clk);
    checkIdle("b2bAfter", 16'h0001);

    // Reset lands on the edge that would commit the write.
    @(negedge clk);
    mem_wr = 1'b1; addr = 8'h20; wdata = 16'h1234;
    @(negedge clk);
    mem_wr = 1'b0;
    checkOutput("rstBusyWait", 16'(wait_), 16'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdle("rstAbort", 16'h0000);
    reset = 1'b0;
    applyStimulus("rd20Kept", 1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 16'h5555, 1'b0);

    // Strobes wiggled while BUSY must be ignored.
    @(negedge clk);
    mem_rd = 1'b1; addr = 8'h12;
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b1; addr = 8'h20; wdata = 16'hFFFF;
    checkOutput("togWait1", 16'(wait_), 16'h1);
    @(negedge clk);
    mem_rd = 1'b1; mem_wr = 1'b0;
    checkOutput("togWait2", 16'(wait_), 16'h1);
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0;
    checkOutput("togDoneWait",  16'(wait_), 16'h0);
    checkOutput("togDoneValid", 16'(rdata_valid), 16'h1);
    checkOutput("togDoneRdata", rdata, 16'hBEEF);
    @(negedge clk);
    checkIdle("togAfter", 16'hBEEF);
    applyStimulus("rd20NoWr", 1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 16'h5555, 1'b0);

`ifdef MEM_RESP_PARITY_EN
    applyStimulus("wr00ff", 1'b0, 1'b1, 8'h40, 16'h00FF, 1'b0, 16'h5555, 1'b0);
    @(negedge clk);
    dut.u_ram.r_mem[8'h40][16] = ~dut.u_ram.r_mem[8'h40][16];
    applyStimulus("rdBadPar", 1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 16'h00FF, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
